// File: rtl/led_pkg.sv
// Shared types and helpers for the LED step controller: debounce FSM
// state encoding and the speed-to-divisor mapping used by the step divider.
package led_pkg;

  localparam int unsigned SPEED_W = 2;
  localparam int unsigned SUB_W   = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFiltDn = 2'd1,
    StDown   = 2'd2,
    StFiltUp = 2'd3
  } key_state_e;

  // Number of base wraps minus one between steps: 8, 4, 2, 1 wraps.
  function automatic logic [SUB_W-1:0] speed_div(input logic [SPEED_W-1:0] speed);
    logic [SUB_W-1:0] div;
    unique case (speed)
      2'd0:    div = 3'd7;
      2'd1:    div = 3'd3;
      2'd2:    div = 3'd1;
      default: div = 3'd0;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/led_step_ctrl_if.sv
// Key inputs and step/direction/speed outputs of the LED step controller.
interface led_step_ctrl_if;
  import led_pkg::*;

  logic [1:0]         key_in;
  logic               step_tick;
  logic               dir;
  logic [SPEED_W-1:0] speed;

  modport master (output key_in, input step_tick, input dir, input speed);
  modport slave  (input key_in, output step_tick, output dir, output speed);

endinterface

// File: rtl/key_filter.sv
// Synchronizes one active-low push-button and debounces it; emits a
// single-cycle press flag once the key has been stably low for the filter time.
module key_filter
  import led_pkg::*;
#(
  parameter logic [19:0] CNT_20MS_MAX = 20'd999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key,
  output logic press
);

  logic       key_meta_q;
  logic       key_sync_q;
  key_state_e state_q;
  logic [19:0] cnt_q;

  // Two-flop synchronizer; idles high because the key is active-low.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key;
      key_sync_q <= key_meta_q;
    end
  end

  // Debounce FSM with registered press flag; only the filtered press edge flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!key_sync_q) begin
            state_q <= StFiltDn;
            cnt_q   <= '0;
          end
        end
        StFiltDn: begin
          if (key_sync_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_20MS_MAX) begin
            state_q <= StDown;
            cnt_q   <= '0;
            press   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        StDown: begin
          if (key_sync_q) begin
            state_q <= StFiltUp;
            cnt_q   <= '0;
          end
        end
        StFiltUp: begin
          if (!key_sync_q) begin
            state_q <= StDown;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_20MS_MAX) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_step_ctrl.sv
// Water-LED step controller: two debounced keys select speed (0..3) and
// direction; a base/sub divider emits one step_tick per step period.
module led_step_ctrl
  import led_pkg::*;
#(
  parameter logic [19:0] CNT_20MS_MAX = 20'd999_999,
  parameter logic [24:0] CNT_BASE_MAX = 25'd24_999_999
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  led_step_ctrl_if.slave  bus
);

  logic               speed_press;
  logic               dir_press;
  logic [24:0]        base_q;
  logic [SUB_W-1:0]   sub_q;
  logic               tick_q;
  logic               dir_q;
  logic [SPEED_W-1:0] speed_q;

  key_filter #(
    .CNT_20MS_MAX (CNT_20MS_MAX)
  ) u_key_speed (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (bus.key_in[0]),
    .press   (speed_press)
  );

  key_filter #(
    .CNT_20MS_MAX (CNT_20MS_MAX)
  ) u_key_dir (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .key     (bus.key_in[1]),
    .press   (dir_press)
  );

  // Speed/dir registers and step divider; a speed change restarts the period.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      base_q  <= '0;
      sub_q   <= '0;
      tick_q  <= 1'b0;
      dir_q   <= 1'b0;
      speed_q <= '0;
    end else begin
      tick_q <= 1'b0;
      if (dir_press) begin
        dir_q <= ~dir_q;
      end
      if (speed_press) begin
        speed_q <= speed_q + 2'd1;
        base_q  <= '0;
        sub_q   <= '0;
      end else if (base_q == CNT_BASE_MAX) begin
        base_q <= '0;
        if (sub_q == speed_div(speed_q)) begin
          sub_q  <= '0;
          tick_q <= 1'b1;
        end else begin
          sub_q <= sub_q + 3'd1;
        end
      end else begin
        base_q <= base_q + 25'd1;
      end
    end
  end

  assign bus.step_tick = tick_q;
  assign bus.dir       = dir_q;
  assign bus.speed     = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// Directed bench for led_step_ctrl with a short debounce (9) and base period (4).
module tb_led_step_ctrl;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;

  led_step_ctrl_if bus_if ();

  led_step_ctrl #(
    .CNT_20MS_MAX (20'd9),
    .CNT_BASE_MAX (25'd4)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus_if.slave)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Observation state, written only by the monitor processes.
  int         cyc = 0;
  int         tick_times[$];
  int         spd_changes = 0;
  int         dir_changes = 0;
  int         spd_chg_cyc = 0;
  int         dir_chg_cyc = 0;
  logic [1:0] last_spd = 2'd0;
  logic       last_dir = 1'b0;

  // Count rising edges so events can be timed in cycles.
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record ticks and output changes on the falling edge.
  always @(negedge sys_clk) begin
    if (bus_if.step_tick) tick_times.push_back(cyc);
    if (bus_if.speed != last_spd) begin
      spd_changes = spd_changes + 1;
      spd_chg_cyc = cyc;
    end
    if (bus_if.dir != last_dir) begin
      dir_changes = dir_changes + 1;
      dir_chg_cyc = cyc;
    end
    last_spd = bus_if.speed;
    last_dir = bus_if.dir;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance n cycles and settle just past the falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  function automatic int tick_after(input int c);
    foreach (tick_times[i]) if (tick_times[i] > c) return tick_times[i];
    return -100000;
  endfunction

  task automatic press_key(input logic [1:0] mask, input int low_n, input int high_n);
    bus_if.key_in = ~mask;
    step(low_n);
    bus_if.key_in = 2'b11;
    step(high_n);
  endtask

  task automatic do_reset(output int rel);
    sys_rst = 1'b1;
    bus_if.key_in = 2'b11;
    step(3);
    check_eq("rst_tick", int'(bus_if.step_tick), 0);
    check_eq("rst_dir", int'(bus_if.dir), 0);
    check_eq("rst_speed", int'(bus_if.speed), 0);
    sys_rst = 1'b0;
    rel = cyc;
  endtask

  initial begin
    int rel, t1, t2, t3, base_spd, base_dir;
    bus_if.key_in = 2'b11;

    // Reset and idle speed 0: first tick 40 cycles after release, then every 40.
    do_reset(rel);
    step(100);
    t1 = tick_after(rel);
    t2 = tick_after(t1);
    check_eq("first_tick", t1 - rel, 40);
    check_eq("period_s0", t2 - t1, 40);
    check_eq("dir_idle", int'(bus_if.dir), 0);
    check_eq("speed_idle", int'(bus_if.speed), 0);

    // Long clean press: one flag, speed 1, period 20 from the change.
    base_spd = spd_changes;
    press_key(2'b01, 50, 60);
    check_eq("long_press_flags", spd_changes - base_spd, 1);
    check_eq("long_press_speed", int'(bus_if.speed), 1);
    t1 = tick_after(spd_chg_cyc);
    t2 = tick_after(t1);
    check_eq("s1_first_tick", t1 - spd_chg_cyc, 20);
    check_eq("s1_period", t2 - t1, 20);

    // Bouncy press then bouncy release: exactly one increment.
    base_spd = spd_changes;
    for (int i = 0; i < 10; i++) begin
      bus_if.key_in = (i % 2 == 0) ? 2'b10 : 2'b11;
      step(3);
    end
    check_eq("bounce_no_flag", spd_changes - base_spd, 0);
    bus_if.key_in = 2'b10;
    step(20);
    for (int i = 0; i < 10; i++) begin
      bus_if.key_in = (i % 2 == 0) ? 2'b11 : 2'b10;
      step(3);
    end
    bus_if.key_in = 2'b11;
    step(30);
    check_eq("bounce_flags", spd_changes - base_spd, 1);
    check_eq("bounce_speed", int'(bus_if.speed), 2);

    // Four clean presses from reset: 1, 2, 3, 0; speed 3 ticks every 5.
    do_reset(rel);
    press_key(2'b01, 20, 20);
    check_eq("p1_speed", int'(bus_if.speed), 1);
    press_key(2'b01, 20, 20);
    check_eq("p2_speed", int'(bus_if.speed), 2);
    press_key(2'b01, 20, 40);
    check_eq("p3_speed", int'(bus_if.speed), 3);
    t1 = tick_after(spd_chg_cyc);
    t2 = tick_after(t1);
    t3 = tick_after(t2);
    check_eq("s3_first_tick", t1 - spd_chg_cyc, 5);
    check_eq("s3_period_a", t2 - t1, 5);
    check_eq("s3_period_b", t3 - t2, 5);
    press_key(2'b01, 20, 20);
    check_eq("p4_speed_wrap", int'(bus_if.speed), 0);

    // Both keys in the same cycle: speed and dir change together, phase restarts.
    base_spd = spd_changes;
    base_dir = dir_changes;
    press_key(2'b11, 20, 60);
    check_eq("both_speed", int'(bus_if.speed), 1);
    check_eq("both_dir", int'(bus_if.dir), 1);
    check_eq("both_spd_flags", spd_changes - base_spd, 1);
    check_eq("both_dir_flags", dir_changes - base_dir, 1);
    check_eq("both_same_edge", dir_chg_cyc, spd_chg_cyc);
    t1 = tick_after(spd_chg_cyc);
    check_eq("both_phase", t1 - spd_chg_cyc, 20);

    // Reset while filtering a press: no flag afterwards, clean restart.
    bus_if.key_in = 2'b10;
    step(7);
    do_reset(rel);
    base_spd = spd_changes;
    base_dir = dir_changes;
    step(50);
    check_eq("mid_rst_flags", spd_changes - base_spd, 0);
    check_eq("mid_rst_dir_flags", dir_changes - base_dir, 0);
    check_eq("mid_rst_speed", int'(bus_if.speed), 0);
    check_eq("mid_rst_dir", int'(bus_if.dir), 0);
    check_eq("mid_rst_first_tick", tick_after(rel) - rel, 40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_step_ctrl.md
LED_STEP_CTRL -- requirements
Module: led_step_ctrl

Interface
REQ-001 Parameter CNT_20MS_MAX, default 20'd999_999, debounce count (20 ms at 50 MHz).
REQ-002 Parameter CNT_BASE_MAX, default 25'd24_999_999, base step period minus one, in cycles.
REQ-003 sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-high reset.
REQ-005 key_in  input  2  raw push-buttons, active-low, asynchronous to sys_clk; bit0 = speed key, bit1 = direction key.
REQ-006 step_tick  output  1  one-cycle pulse requesting one water-LED shift.
REQ-007 dir  output  1  shift direction; 0 = toward led[3], 1 = toward led[0].
REQ-008 speed  output  2  current speed level 0..3.

Function
REQ-009 Each key_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Each key SHALL have a debounce FSM with states IDLE, FILT_DN, DOWN, FILT_UP.
REQ-011 IDLE: synchronized key low -> FILT_DN with counter 0; otherwise stay.
REQ-012 FILT_DN: key low -> counter +1; key high -> IDLE, counter cleared; counter == CNT_20MS_MAX with key low -> DOWN.
REQ-013 On the FILT_DN->DOWN transition the key's press flag SHALL be high for exactly one cycle.
REQ-014 DOWN: key high -> FILT_UP, counter 0; held low -> stay, no further flags (no auto-repeat).
REQ-015 FILT_UP: key high -> counter +1, reaching CNT_20MS_MAX -> IDLE; key low -> DOWN, counter cleared, no flag.
REQ-016 Speed-key flag SHALL increment speed by 1, modulo 4 (3 -> 0).
REQ-017 Direction-key flag SHALL toggle dir.
REQ-018 Flags from both keys in the same cycle SHALL both take effect in that cycle.
REQ-019 A base counter SHALL count 0..CNT_BASE_MAX and wrap; each wrap increments a 3-bit sub-counter.
REQ-020 step_tick SHALL pulse on the base wrap at which the sub-counter equals (1 << (3 - speed)) - 1; the sub-counter then clears.
REQ-021 Step period SHALL be (CNT_BASE_MAX+1) x 8, 4, 2, 1 cycles for speed 0, 1, 2, 3.
REQ-022 Any speed change SHALL clear base and sub-counters on the next edge; the first tick at the new speed follows one full new period.
REQ-023 A dir change SHALL NOT disturb the counters.
REQ-024 step_tick, dir and speed SHALL be registered outputs.

Reset
REQ-025 While sys_rst is high: step_tick = 0, dir = 0, speed = 0, both FSMs IDLE, all counters and synchronizer flops cleared (synchronizers to 1).
REQ-026 Reset asserted mid-filter or mid-period SHALL discard partial progress; no flag and no tick SHALL be produced by that sequence after release.
REQ-027 The first tick after reset release SHALL occur (CNT_BASE_MAX+1) x 8 cycles later.

Structure
REQ-028 FSM state encodings and speed-to-divisor mapping SHALL reside in shared package led_pkg.
REQ-029 The debounce FSM with counter and synchronizer SHALL be sub-module key_filter, parameterized by CNT_20MS_MAX, instantiated once per key.
REQ-030 Speed/dir registers and the step divider SHALL live in led_step_ctrl.

Verification (CNT_20MS_MAX = 9, CNT_BASE_MAX = 4)
REQ-031 Reset, keys high, speed 0 -> step_tick every 40 cycles, first pulse 40 cycles after release; dir = 0.
REQ-032 key_in[0] low for 50 cycles, then high -> exactly one flag, speed 0 -> 1; ticks every 20 cycles after the change.
REQ-033 key_in[0] toggling every 3 cycles for 30 cycles, then stable low for 20 -> exactly one speed increment; release bounce -> none.
REQ-034 Four clean speed-key presses -> speed 1, 2, 3, 0; at speed 3, step_tick every 5 cycles.
REQ-035 Both keys pressed in the same cycle -> speed and dir change on the same edge; tick phase restarts.
REQ-036 sys_rst pulsed 5 cycles into FILT_DN -> no flag after release, outputs at reset values.
